instruction_sequencer: RTL

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/isa_pkg.sv | 50 +++++
 rtl/instruction_decode.sv | 70 +++++++
 rtl/instruction_sequencer.sv | 88 ++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction sequencer: opcode fields, register codes,
// bus-source selects, write-enable bit positions and sequencer states.
package isa_pkg;

    localparam logic [7:0] NOP = 8'hF0;

    localparam logic [2:0] OP_ALU  = 3'b110;
    localparam logic [3:0] OP_CTRL = 4'b1110;

    localparam logic [3:0] CTL_JMP  = 4'b0000;
    localparam logic [3:0] CTL_JZ   = 4'b0001;
    localparam logic [3:0] CTL_JNZ  = 4'b0010;
    localparam logic [3:0] CTL_HALT = 4'b1111;

    localparam logic [2:0] DST_X0 = 3'd0;
    localparam logic [2:0] DST_X1 = 3'd1;
    localparam logic [2:0] DST_Y0 = 3'd2;
    localparam logic [2:0] DST_Y1 = 3'd3;
    localparam logic [2:0] DST_O  = 3'd4;
    localparam logic [2:0] DST_M  = 3'd5;
    localparam logic [2:0] DST_I  = 3'd6;
    localparam logic [2:0] DST_DM = 3'd7;

    localparam logic [3:0] SRC_SEL_IMM  = 4'd8;
    localparam logic [3:0] SRC_SEL_PINS = 4'd9;

    localparam int RE_X0 = 0;
    localparam int RE_X1 = 1;
    localparam int RE_Y0 = 2;
    localparam int RE_Y1 = 3;
    localparam int RE_R  = 4;
    localparam int RE_M  = 5;
    localparam int RE_I  = 6;
    localparam int RE_DM = 7;
    localparam int RE_O  = 8;

    // Two-bit encoding so the illegal codes 00/11 exist and recover to RUN.
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    // dst codes map 1:1 onto enable bits except o_reg, which lives above r.
    function automatic logic [8:0] dst_en(input logic [2:0] d);
        logic [8:0] e;
        e = '0;
        if (d == DST_O) e[RE_O] = 1'b1;
        else            e[d]    = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/instruction_decode.sv
// Combinational decode of ir and sequencer state into datapath controls and jump decision.
// Zero latency; everything is forced to 0 outside RUN.
module instruction_decode
    import isa_pkg::*;
(
    input  logic [7:0] ir_i,
    input  logic [1:0] state_i,
    input  logic       r_eq_0_i,
    output logic [3:0] ir_nibble_o,
    output logic [3:0] source_sel_o,
    output logic [8:0] reg_en_o,
    output logic       i_sel_o,
    output logic       x_sel_o,
    output logic       y_sel_o,
    output logic       is_jump_o,
    output logic       jump_taken_o,
    output logic       is_halt_o
);

    logic [2:0] dst;
    logic [2:0] src;

    always_comb begin
        ir_nibble_o  = '0;
        source_sel_o = '0;
        reg_en_o     = '0;
        i_sel_o      = 1'b0;
        x_sel_o      = 1'b0;
        y_sel_o      = 1'b0;
        is_jump_o    = 1'b0;
        jump_taken_o = 1'b0;
        is_halt_o    = 1'b0;
        dst          = ir_i[6:4];
        src          = ir_i[2:0];

        if (state_i == ST_RUN) begin
            ir_nibble_o = ir_i[3:0];
            if (!ir_i[7]) begin
                reg_en_o     = dst_en(dst);
                source_sel_o = SRC_SEL_IMM;
                if (dst == DST_DM) begin
                    reg_en_o[RE_I] = 1'b1;
                    i_sel_o        = 1'b1;
                end
            end else if (!ir_i[6]) begin
                // A move onto itself is repurposed to read the external input pins.
                dst          = ir_i[5:3];
                reg_en_o     = dst_en(dst);
                source_sel_o = (dst == src) ? SRC_SEL_PINS : {1'b0, src};
                if ((src == DST_DM || dst == DST_DM) && dst != DST_I) begin
                    reg_en_o[RE_I] = 1'b1;
                    i_sel_o        = 1'b1;
                end
            end else if (ir_i[7:5] == OP_ALU) begin
                reg_en_o[RE_R] = 1'b1;
                x_sel_o        = ir_i[4];
                y_sel_o        = ir_i[3];
            end else if (ir_i[7:4] == OP_CTRL) begin
                case (ir_i[3:0])
                    CTL_JMP:  begin is_jump_o = 1'b1; jump_taken_o = 1'b1;      end
                    CTL_JZ:   begin is_jump_o = 1'b1; jump_taken_o = r_eq_0_i;  end
                    CTL_JNZ:  begin is_jump_o = 1'b1; jump_taken_o = !r_eq_0_i; end
                    CTL_HALT: is_halt_o = 1'b1;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/sequence controller: one instruction per RUN cycle, two-byte jumps with a NOP bubble,
// HALT until go. No backpressure; the program memory is read combinationally at pc.
module instruction_sequencer
    import isa_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      pm_data,
    input  logic            r_eq_0,
    input  logic            go,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      ir_nibble,
    output logic [3:0]      source_sel,
    output logic [8:0]      reg_en,
    output logic            i_sel,
    output logic            x_sel,
    output logic            y_sel,
    output logic            cu_sync_reset,
    output logic            halted
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [1:0]      state_q, state_d;
    logic            cu_rst_q;
    logic            is_jump, jump_taken, is_halt;

    instruction_decode u_decode (
        .ir_i         (ir_q),
        .state_i      (state_q),
        .r_eq_0_i     (r_eq_0),
        .ir_nibble_o  (ir_nibble),
        .source_sel_o (source_sel),
        .reg_en_o     (reg_en),
        .i_sel_o      (i_sel),
        .x_sel_o      (x_sel),
        .y_sel_o      (y_sel),
        .is_jump_o    (is_jump),
        .jump_taken_o (jump_taken),
        .is_halt_o    (is_halt)
    );

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        state_d = ST_RUN;
        case (state_q)
            ST_RUN: begin
                if (is_halt) begin
                    state_d = ST_HALT;
                end else if (is_jump) begin
                    // pm_data is the target byte here; the fetched word is replaced by a bubble.
                    pc_d = jump_taken ? PC_W'(pm_data) : pc_q + PC_W'(1);
                    ir_d = NOP;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                    ir_d = pm_data;
                end
            end
            ST_HALT: begin
                if (go) ir_d = NOP;
                else    state_d = ST_HALT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            ir_q     <= NOP;
            state_q  <= ST_RUN;
            cu_rst_q <= 1'b1;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            state_q  <= state_d;
            cu_rst_q <= 1'b0;
        end
    end

    assign pc            = pc_q;
    assign cu_sync_reset = cu_rst_q;
    assign halted        = (state_q == ST_HALT);

endmodule
